// File: rtl/fetch_pkg.sv
// Shared constants and the buffered fetch entry type for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Flush clears occupancy and pointers; reset additionally zeroes the entries.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entries [DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = entries[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory, buffers returned
// instructions and hands them to decode over valid/ready.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and
// raises fetch_fault until reset or an aligned redirect. Without it the low
// two bits of redirect_pc are dropped and fetch_fault is tied low.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int              IMEM_W   = 64,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [IMEM_W-1:0] imem_instr,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_pc,
  output logic [31:0]       if_instr,
  output logic              fetch_fault
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] load_pc;
  logic            halt_q;
  logic            fetch_fire;
  logic            pop;
  logic [1:0]      count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            unused_upper;

  // Upper half of the memory port carries nothing for this stage.
  assign unused_upper = ^imem_instr[IMEM_W-1:ILEN];

  // Occupancy comes from registers only, so decode back-pressure never reaches imem_addr.
  assign fetch_fire = !reset && !redirect && (count < DEPTH_C) && !halt_q;
  assign pop        = if_valid && if_ready;
  assign imem_addr  = pc_q;
  assign if_valid   = (count != 2'd0) && !redirect;
  assign if_pc      = head.pc;
  assign if_instr   = head.instr;
  assign push_entry = '{pc: pc_q, instr: imem_instr[ILEN-1:0]};

`ifdef FETCH_MISALIGN_TRAP_EN
  // Keep the raw target so a misaligned PC is visible on imem_addr while halted.
  assign load_pc     = redirect_pc;
  assign fetch_fault = halt_q;

  // Halt latch: set by a misaligned redirect, cleared by reset or an aligned redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (redirect) begin
      halt_q <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_low;

  assign unused_low  = ^redirect_pc[1:0];
  assign load_pc     = {redirect_pc[XLEN-1:2], 2'b00};
  assign halt_q      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Program counter: reset beats redirect, redirect beats sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= load_pc;
    end else if (fetch_fire) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (fetch_fire),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: per-cycle vector table plus
// a scoreboard of expected decode handshakes.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [63:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ep;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  // Memory model: a distinct word per address; upper half is junk the DUT must ignore.
  function automatic logic [31:0] mem_lo(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  assign imem_instr = {~imem_addr, mem_lo(imem_addr)};

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .fetch_fault (fetch_fault)
  );

  function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rpc,
                              input logic rdy, input logic chk, input logic ev,
                              input logic [31:0] ea, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.ea = ea; v.ep = ep; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Score any handshake happening this cycle, then advance one clock.
  task automatic tick();
    logic [63:0] e;
    if (if_valid && if_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake: unexpected pc %h got, none expected", if_pc);
      end else begin
        e = sb.pop_front();
        chk("hs_pc", if_pc, e[63:32]);
        chk("hs_instr", if_instr, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset       = v.rst;
    redirect    = v.rdr;
    redirect_pc = v.rpc;
    if_ready    = v.rdy;
    #1;
    if (v.chk) begin
      chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v.ev});
      chk({tag, ".addr"}, imem_addr, v.ea);
      chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, v.ef});
      if (v.ev) begin
        chk({tag, ".pc"}, if_pc, v.ep);
        chk({tag, ".instr"}, if_instr, mem_lo(v.ep));
        if (v.rdy) sb.push_back({v.ep, mem_lo(v.ep)});
      end
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    if_ready    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.valid", {31'b0, if_valid}, 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.instr", if_instr, 32'h0);
    chk("rst.fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);

    // Streaming from reset.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h8, 32'h4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC, 32'h8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    // Back-pressure from reset: buffer saturates, then drains in order.
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h4, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h8, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h8, 32'h4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC, 32'h8, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h10, 32'hC, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h14, 32'h10, 0));
    // Redirect with a full buffer (0x10, 0x14) to 0x100.
    tbl.push_back(mk(0, 1, 32'h100, 1, 1, 0, 32'h18, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h100, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h104, 32'h100, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h108, 32'h104, 0));
    // PC wrap at the top of the address space.
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'h10C, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0, 32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0, 0));
    // Reset while full with a redirect pending.
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h4, 0));
    tbl.push_back(mk(1, 1, 32'h300, 0, 1, 0, 32'hC, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h4, 0));
    // Back-to-back redirects: the last one wins.
    tbl.push_back(mk(0, 1, 32'h400, 1, 1, 0, 32'hC, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h500, 1, 1, 0, 32'h400, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h500, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h504, 32'h500, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h508, 32'h504, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Misaligned redirect to 0x102, then an aligned redirect to 0x200.
    apply(mk(0, 1, 32'h102, 1, 1, 0, 32'h50C, 32'h0, 0), "mis0");
`ifdef FETCH_MISALIGN_TRAP_EN
    apply(mk(0, 0, 0, 1, 1, 0, 32'h102, 32'h0, 1), "mis1");
    apply(mk(0, 0, 0, 1, 1, 0, 32'h102, 32'h0, 1), "mis2");
    apply(mk(0, 1, 32'h200, 1, 1, 0, 32'h102, 32'h0, 1), "mis3");
    apply(mk(0, 0, 0, 1, 1, 0, 32'h200, 32'h0, 0), "mis4");
    apply(mk(0, 0, 0, 1, 1, 1, 32'h204, 32'h200, 0), "mis5");
`else
    apply(mk(0, 0, 0, 1, 1, 0, 32'h100, 32'h0, 0), "mis1");
    apply(mk(0, 0, 0, 1, 1, 1, 32'h104, 32'h100, 0), "mis2");
    apply(mk(0, 1, 32'h200, 1, 1, 0, 32'h108, 32'h0, 0), "mis3");
    apply(mk(0, 0, 0, 1, 1, 0, 32'h200, 32'h0, 0), "mis4");
    apply(mk(0, 0, 0, 1, 1, 1, 32'h204, 32'h200, 0), "mis5");
`endif

    if_ready = 1'b0;
    redirect = 1'b0;
    tick();
    chk("sb_empty", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
